// File: rtl/pwm_pkg.sv
// pwm_pkg: types and reset constants shared by the multi-channel PWM files.
package pwm_pkg;

  // Counting style of the shared period counter.
  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_e;

  // Widest counter the reset constants cover; modules slice to CTR_LEN.
  localparam int PWM_MAX_W = 32;

  // Period comes out of reset as all-ones, compares as zero (outputs low).
  localparam logic [PWM_MAX_W-1:0] PWM_PERIOD_RST  = '1;
  localparam logic [PWM_MAX_W-1:0] PWM_COMPARE_RST = '0;

endpackage

// File: rtl/pwm_cmp_ch.sv
// pwm_cmp_ch: one PWM channel -- active compare register, unsigned
// comparator against the shared counter, and the registered output.
module pwm_cmp_ch
  import pwm_pkg::*;
#(
  parameter int CTR_LEN = 10
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_en,
  input  logic               i_apply,
  input  logic [CTR_LEN-1:0] i_cmpShadow,
  input  logic [CTR_LEN-1:0] i_cnt,
  output logic               o_pwm
);

  localparam logic [CTR_LEN-1:0] L_CMP_RST = PWM_COMPARE_RST[CTR_LEN-1:0];

  logic [CTR_LEN-1:0] r_cmpAct;
  logic               r_pwm;

  // Take the shadow compare only at a boundary that carries a pending update.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cmpAct <= L_CMP_RST;
    end else if (i_apply) begin
      r_cmpAct <= i_cmpShadow;
    end
  end

  // Output is high while the counter is below the compare; forced low when disabled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pwm <= 1'b0;
    end else if (!i_en) begin
      r_pwm <= 1'b0;
    end else begin
      r_pwm <= (r_cmpAct > i_cnt);
    end
  end

  assign o_pwm = r_pwm;

endmodule

// File: rtl/pwm_multi_ch.sv
// pwm_multi_ch: shared period counter driving CHANNELS duty comparators.
// Period, compares (and mode) are double-buffered and only become active
// at a period boundary, so pulses are never truncated or glitched.
// Optional feature macro: PWM_CENTER_ALIGN_EN adds the mode_in port and an
// up/down counter for center-aligned operation; without it the block is
// edge-aligned only.
module pwm_multi_ch
  import pwm_pkg::*;
#(
  parameter int CTR_LEN  = 10,
  parameter int CHANNELS = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic                         load,
  input  logic [CTR_LEN-1:0]           period_in,
  input  logic [CHANNELS*CTR_LEN-1:0]  compare_in,
`ifdef PWM_CENTER_ALIGN_EN
  input  logic                         mode_in,
`endif
  output logic [CHANNELS-1:0]          pwm,
  output logic                         period_end,
  output logic                         pending
);

  localparam logic [CTR_LEN-1:0] L_PERIOD_RST = PWM_PERIOD_RST[CTR_LEN-1:0];
  localparam logic [CTR_LEN-1:0] L_CMP_RST    = PWM_COMPARE_RST[CTR_LEN-1:0];
  localparam logic [CTR_LEN-1:0] L_ONE        = {{(CTR_LEN-1){1'b0}}, 1'b1};

  logic [CTR_LEN-1:0]          r_cnt;
  logic [CTR_LEN-1:0]          r_periodAct;
  logic [CTR_LEN-1:0]          r_periodShd;
  logic [CHANNELS*CTR_LEN-1:0] r_cmpShd;
  logic                        r_pending;
  logic                        r_periodEnd;

  logic [CTR_LEN-1:0]          w_edgeNext;
  logic [CTR_LEN-1:0]          w_cntNext;
  logic                        w_boundary;
  logic                        w_apply;
  logic [CHANNELS-1:0]         w_pwm;

  // Edge-aligned sequence 0..P then wrap; the >= also covers P = 0.
  assign w_edgeNext = (r_cnt >= r_periodAct) ? '0 : (r_cnt + L_ONE);

`ifdef PWM_CENTER_ALIGN_EN
  pwm_mode_e r_modeAct;
  pwm_mode_e r_modeShd;
  logic      r_dirDown;
  logic      w_dirDownNext;

  // Center mode runs 0 up to P, P-1 down to 1, then back to 0 (2P clocks).
  always_comb begin
    w_cntNext     = w_edgeNext;
    w_dirDownNext = 1'b0;
    if (r_modeAct == PWM_CENTER) begin
      if (r_dirDown) begin
        if (r_cnt <= L_ONE) begin
          w_cntNext     = '0;
          w_dirDownNext = 1'b0;
        end else begin
          w_cntNext     = r_cnt - L_ONE;
          w_dirDownNext = 1'b1;
        end
      end else if (r_cnt >= r_periodAct) begin
        if (r_periodAct <= L_ONE) begin
          w_cntNext     = '0;
          w_dirDownNext = 1'b0;
        end else begin
          w_cntNext     = r_periodAct - L_ONE;
          w_dirDownNext = 1'b1;
        end
      end else begin
        w_cntNext     = r_cnt + L_ONE;
        w_dirDownNext = 1'b0;
      end
    end
  end

  // Direction flag follows the counter and restarts upward when disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dirDown <= 1'b0;
    end else if (!en) begin
      r_dirDown <= 1'b0;
    end else begin
      r_dirDown <= w_dirDownNext;
    end
  end

  // Mode is shadowed with period/compare and switches only at a boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_modeShd <= PWM_EDGE;
      r_modeAct <= PWM_EDGE;
    end else begin
      if (load) begin
        r_modeShd <= pwm_mode_e'(mode_in);
      end
      if (w_apply) begin
        r_modeAct <= r_modeShd;
      end
    end
  end
`else
  assign w_cntNext = w_edgeNext;
`endif

  // A boundary is any enabled cycle whose next count is 0.
  assign w_boundary = en & (w_cntNext == '0);
  assign w_apply    = w_boundary & r_pending;

  // Shared period counter; disabling parks it at 0 so restart gives a full period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!en) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cntNext;
    end
  end

  // Shadow capture on load; a load in the boundary cycle keeps pending set,
  // while the active side still receives the pre-load shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_periodShd <= L_PERIOD_RST;
      r_cmpShd    <= {CHANNELS{L_CMP_RST}};
      r_pending   <= 1'b0;
    end else begin
      if (load) begin
        r_periodShd <= period_in;
        r_cmpShd    <= compare_in;
      end
      r_pending <= load | (r_pending & ~w_boundary);
    end
  end

  // Active period is swapped in together with the channel compares.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_periodAct <= L_PERIOD_RST;
    end else if (w_apply) begin
      r_periodAct <= r_periodShd;
    end
  end

  // One-clock boundary marker aligned with the pwm sample of the last count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_periodEnd <= 1'b0;
    end else begin
      r_periodEnd <= w_boundary;
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    pwm_cmp_ch #(
      .CTR_LEN (CTR_LEN)
    ) u_ch (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_en        (en),
      .i_apply     (w_apply),
      .i_cmpShadow (r_cmpShd[gi*CTR_LEN +: CTR_LEN]),
      .i_cnt       (r_cnt),
      .o_pwm       (w_pwm[gi])
    );
  end

  assign pwm        = w_pwm;
  assign period_end = r_periodEnd;
  assign pending    = r_pending;

endmodule

// File: tb/tb_pwm_multi_ch.sv
// tb_pwm_multi_ch: directed, table-driven check of pwm_multi_ch with
// CTR_LEN = 10 and CHANNELS = 4. Center-aligned sequence is exercised
// only when PWM_CENTER_ALIGN_EN is defined.
`timescale 1ns/1ps
module tb_pwm_multi_ch;

  localparam int CTR_LEN  = 10;
  localparam int CHANNELS = 4;

  // Compare sets are packed {ch3, ch2, ch1, ch0}.
  localparam logic [39:0] C_A = {10'd15, 10'd10, 10'd3, 10'd0};

  typedef struct {
    logic        en;
    logic        load;
    logic [9:0]  period;
    logic [39:0] compare;
    logic [3:0]  expPwm;
    logic        expPe;
    logic        expPend;
  } vec_t;

  vec_t vecs[$];

  logic                        clk;
  logic                        rst_n;
  logic                        en;
  logic                        load;
  logic [CTR_LEN-1:0]          period_in;
  logic [CHANNELS*CTR_LEN-1:0] compare_in;
`ifdef PWM_CENTER_ALIGN_EN
  logic                        mode_in;
`endif
  logic [CHANNELS-1:0]         pwm;
  logic                        period_end;
  logic                        pending;

  int nCompared   = 0;
  int nMismatched = 0;

  pwm_multi_ch #(
    .CTR_LEN  (CTR_LEN),
    .CHANNELS (CHANNELS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load       (load),
    .period_in  (period_in),
    .compare_in (compare_in),
`ifdef PWM_CENTER_ALIGN_EN
    .mode_in    (mode_in),
`endif
    .pwm        (pwm),
    .period_end (period_end),
    .pending    (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one clock of inputs, then return at the following falling edge.
  task automatic applyStimulus(input logic e, input logic l,
                               input logic [9:0] p, input logic [39:0] c);
    en         = e;
    load       = l;
    period_in  = p;
    compare_in = c;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
  endtask

  // Compare the three outputs against bench-computed expectations.
  task automatic checkOutput(input string name, input logic [3:0] expPwm,
                             input logic expPe, input logic expPend);
    nCompared++;
    if (pwm !== expPwm) begin
      nMismatched++;
      $display("[TB] FAIL %s pwm: got %b, expected %b", name, pwm, expPwm);
    end
    nCompared++;
    if (period_end !== expPe) begin
      nMismatched++;
      $display("[TB] FAIL %s period_end: got %b, expected %b", name, period_end, expPe);
    end
    nCompared++;
    if (pending !== expPend) begin
      nMismatched++;
      $display("[TB] FAIL %s pending: got %b, expected %b", name, pending, expPend);
    end
  endtask

  task automatic stepCheck(input string name, input logic e, input logic l,
                           input logic [9:0] p, input logic [39:0] c,
                           input logic [3:0] expPwm, input logic expPe,
                           input logic expPend);
    applyStimulus(e, l, p, c);
    checkOutput(name, expPwm, expPe, expPend);
  endtask

  // One 10-clock period at P = 9 with ch0=0, ch2=10, ch3=15; ch1 is high
  // for 'hi' clocks. Optional load of a new ch1 compare at slot loadK.
  task automatic pushPeriod(input int hi, input int loadK, input logic [9:0] c1,
                            input int pLo, input int pHi);
    vec_t v;
    for (int k = 0; k < 10; k++) begin
      v.en      = 1'b1;
      v.load    = (k == loadK);
      v.period  = 10'd9;
      v.compare = {10'd15, 10'd10, c1, 10'd0};
      v.expPwm  = (k < hi) ? 4'b1110 : 4'b1100;
      v.expPe   = (k == 9);
      v.expPend = (k >= pLo) && (k <= pHi);
      vecs.push_back(v);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    en         = 1'b0;
    load       = 1'b0;
    period_in  = '0;
    compare_in = '0;
`ifdef PWM_CENTER_ALIGN_EN
    mode_in    = 1'b0;
`endif

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset", 4'b0000, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Default P = 1023, compares 0; load P = 9 set A mid-way through period 3
    for (int s = 1; s <= 3072; s++) begin
      stepCheck($sformatf("idle[%0d]", s), 1'b1, (s == 2049), 10'd9, C_A,
                4'b0000, ((s % 1024) == 0), ((s >= 2049) && (s < 3072)));
    end

    // Table: P = 9 periods with mid-period and boundary-cycle loads
    pushPeriod(3, -1, 10'd3, -1, -2);
    pushPeriod(3,  4, 10'd7,  4,  8);
    pushPeriod(7,  9, 10'd1,  9,  9);
    pushPeriod(7, -1, 10'd1,  0,  8);
    pushPeriod(1, -1, 10'd1, -1, -2);
    for (int i = 0; i < vecs.size(); i++) begin
      stepCheck($sformatf("tbl[%0d]", i), vecs[i].en, vecs[i].load,
                vecs[i].period, vecs[i].compare,
                vecs[i].expPwm, vecs[i].expPe, vecs[i].expPend);
    end

    // Run to count 5, then drop en; load while disabled
    stepCheck("run0", 1'b1, 1'b0, 10'd9, C_A, 4'b1110, 1'b0, 1'b0);
    for (int k = 1; k < 5; k++) begin
      stepCheck($sformatf("run%0d", k), 1'b1, 1'b0, 10'd9, C_A, 4'b1100, 1'b0, 1'b0);
    end
    stepCheck("dis0", 1'b0, 1'b0, 10'd9, C_A, 4'b0000, 1'b0, 1'b0);
    stepCheck("dis1", 1'b0, 1'b1, 10'd9, {10'd15, 10'd10, 10'd5, 10'd0}, 4'b0000, 1'b0, 1'b1);
    stepCheck("dis2", 1'b0, 1'b0, 10'd9, C_A, 4'b0000, 1'b0, 1'b1);
    stepCheck("dis3", 1'b0, 1'b0, 10'd9, C_A, 4'b0000, 1'b0, 1'b1);

    // Re-enable: full first period with old compare 1, then compare 5
    for (int u = 1; u <= 10; u++) begin
      stepCheck($sformatf("reen[%0d]", u), 1'b1, 1'b0, 10'd9, C_A,
                (u == 1) ? 4'b1110 : 4'b1100, (u == 10), (u < 10));
    end
    for (int u = 11; u <= 20; u++) begin
      stepCheck($sformatf("reen[%0d]", u), 1'b1, (u == 12), 10'd0,
                {10'd3, 10'd0, 10'd1, 10'd0},
                (u <= 15) ? 4'b1110 : 4'b1100, (u == 20), ((u >= 12) && (u < 20)));
    end

    // P = 0: every cycle is a boundary
    for (int w = 1; w <= 5; w++) begin
      stepCheck($sformatf("p0[%0d]", w), 1'b1, 1'b0, 10'd0, C_A, 4'b1010, 1'b1, 1'b0);
    end
    stepCheck("p0load", 1'b1, 1'b1, 10'd9, C_A, 4'b1010, 1'b1, 1'b1);

    // Asynchronous reset in the middle of a cycle
    #2 rst_n = 1'b0;
    #1 checkOutput("async_reset", 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int r = 1; r <= 1024; r++) begin
      stepCheck($sformatf("postrst[%0d]", r), 1'b1, 1'b0, 10'd9, C_A,
                4'b0000, (r == 1024), 1'b0);
    end

    // Back-to-back loads: the second (P = 4, ch1 = 2) wins
    for (int r = 1025; r <= 2048; r++) begin
      stepCheck($sformatf("b2b[%0d]", r), 1'b1, ((r == 1025) || (r == 1026)),
                (r == 1025) ? 10'd9 : 10'd4,
                (r == 1025) ? {10'd0, 10'd0, 10'd9, 10'd0} : {10'd0, 10'd0, 10'd2, 10'd0},
                4'b0000, (r == 2048), ((r >= 1025) && (r < 2048)));
    end
    for (int x = 1; x <= 10; x++) begin
      stepCheck($sformatf("b2bp[%0d]", x), 1'b1, 1'b0, 10'd4, C_A,
                (((x - 1) % 5) < 2) ? 4'b0010 : 4'b0000, ((x % 5) == 0), 1'b0);
    end

`ifdef PWM_CENTER_ALIGN_EN
    begin
      // Counts 0,1,2,3,4,3,2,1 with compares ch0=2, ch1=0, ch2=5, ch3=1
      logic [3:0] expC [8];
      expC = '{4'b1101, 4'b0101, 4'b0100, 4'b0100,
               4'b0100, 4'b0100, 4'b0100, 4'b0101};
      rst_n = 1'b0;
      @(negedge clk);
      rst_n   = 1'b1;
      mode_in = 1'b1;
      for (int s = 1; s <= 1024; s++) begin
        stepCheck($sformatf("ctrwait[%0d]", s), 1'b1, (s == 1), 10'd4,
                  {10'd1, 10'd5, 10'd0, 10'd2}, 4'b0000, (s == 1024), (s < 1024));
      end
      for (int v = 1; v <= 16; v++) begin
        stepCheck($sformatf("center[%0d]", v), 1'b1, 1'b0, 10'd4, C_A,
                  expC[(v - 1) % 8], (((v - 1) % 8) == 7), 1'b0);
      end
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/pwm_multi_ch.md
# pwm_multi_ch

Multi-channel PWM generator: one shared period counter drives `CHANNELS` independent duty comparators. Period and compare values are double-buffered and applied together only at a period boundary, so no channel ever produces a glitched or truncated pulse. It sits between the motor/fan control logic and the H-bridge drive pins, and supersedes the single-channel fixed-period PWM.

## Interface
- `CTR_LEN`, 10: counter, period and compare width in bits.
- `CHANNELS`, 4: number of PWM outputs.
- `clk` in 1: system clock; all logic is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset; one clock domain.
- `en` in 1: run enable. 0 holds the counter at 0 and forces outputs low.
- `load` in 1: single-cycle strobe that captures `period_in` and `compare_in` into the shadow registers.
- `period_in` in `CTR_LEN`: period value P.
- `compare_in` in `CHANNELS*CTR_LEN`: per-channel compare values; channel i is at `[i*CTR_LEN +: CTR_LEN]`.
- `mode_in` in 1 (only with `PWM_CENTER_ALIGN_EN`): 0 = edge-aligned, 1 = center-aligned. It is shadowed with the other inputs.
- `pwm` out `CHANNELS`: registered PWM outputs.
- `period_end` out 1: registered pulse marking a boundary.
- `pending` out 1: shadow registers hold values not yet applied.

## Operation
- Reset values:
  - Counter 0, direction up.
  - Active and shadow period all-ones.
  - Active and shadow compares 0.
  - Mode edge-aligned.
  - `pending`, `pwm` and `period_end` all 0.
- Edge-aligned counting: 0, 1, …, P, then wraps to 0. Cycle length is P+1.
- Center-aligned counting: 0 up to P, then P−1 down to 1, then 0. Cycle length is 2P.
- P = 0: the counter stays at 0 in both modes and every cycle is a boundary.
- Boundary: the cycle in which the counter's next value is 0 while `en` = 1. In this cycle the active period, compares and mode are selected for the next period.
- Output rule: `pwm[i]` is registered from `(cmp_act[i] > cnt)`, using an unsigned comparison.
  - Compare 0 gives a constant low output.
  - Compare > P gives a constant high output.
  - Edge mode high time is min(C, P+1) clocks per period.
- Shadowing:
  - `load` = 1 writes the shadow registers and sets `pending`.
  - At a boundary with `pending` = 1, shadow is copied to active and `pending` clears.
- `load` on a boundary cycle: the shadow is overwritten and `pending` ends at 1. The active registers take the pre-load shadow if `pending` was already 1; otherwise they stay unchanged. The new values apply at the next boundary.
- Back-to-back `load`s before a boundary: the last one wins.
- `en` = 0:
  - Counter forced to 0 and direction to up.
  - `pwm` = 0 and `period_end` = 0 from the next edge.
  - `load` and shadowing still operate; no active update occurs.
  - When `en` returns to 1, counting restarts at 0 with the current active values.
- `rst_n` asserted mid-period: all state returns to reset values immediately (asynchronous). The first rising edge after deassertion counts normally.

## Timing
- `pwm` and `period_end` lag the counter by one clock.
- `period_end` is high for exactly one cycle, coincident with the `pwm` sample of the boundary count.
- Latency from `load` to new duty on `pwm`: from the end of the current period plus 1 clock, up to one full period plus 1 clock.
- `pending` rises the clock after `load`. It falls the clock after the applying boundary.

## Configuration
- `PWM_CENTER_ALIGN_EN` defined:
  - `mode_in` port exists.
  - Up/down counter and direction flag are present.
  - Center-aligned mode is selectable per shadow load.
- Not defined:
  - No `mode_in` port and no direction logic.
  - Operation is edge-aligned only.
  - All other behaviour is identical.

## Structure
- Shared package `pwm_pkg`:
  - Mode enum (`PWM_EDGE`, `PWM_CENTER`).
  - Reset constants for period (all-ones) and compare (0).
- One sub-module `pwm_cmp_ch`: per-channel active compare register, comparator and output flop. It is instantiated `CHANNELS` times under generate.
- The counter, boundary detection and shadow control live in the top level.

## Test plan
- Reset, then `en` = 1 with no load, P = 1023 and all compares 0 → every `pwm` low; `period_end` every 1024 clocks.
- Load P = 9 with compares {0, 3, 10, 15}, edge mode → after the first boundary, per 10 clocks: ch0 always low, ch1 high 3 clocks, ch2 and ch3 always high; `pending` clears at that boundary.
- Change compare from 3 to 7 mid-period → the current period keeps 3 high clocks; the next period has 7.
- `load` on the exact boundary cycle with `pending` = 0 → active values unchanged for that period; new values applied one period later.
- Drop `en` mid-period at count 5, then reassert → outputs low the next clock; restart from count 0 with a full first period.
- With `PWM_CENTER_ALIGN_EN`, load P = 4, C = 2, center mode → count sequence 0,1,2,3,4,3,2,1; `pwm` high for counts 0,1,1 (3 of 8 clocks), symmetric around 0; `period_end` every 8 clocks.
